// File: rtl/button_pulser.sv
// button_pulser: debounced, auto-repeating, arbitrated single-cycle button command pulses
module button_pulser #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 32,
    parameter int CW              = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next_raw,
    input  logic       btn_faster_raw,
    input  logic       btn_slower_raw,
    output logic       next,
    output logic       faster,
    output logic       slower,
    output logic [2:0] held
);
    typedef enum logic [1:0] {IDLE, WAIT, REPEAT} rep_t;

    logic [2:0] raw, s1, s2, db, db_q, rise, rep_fire, pend, grant;
    logic       conflict;

    assign raw      = {btn_slower_raw, btn_faster_raw, btn_next_raw};
    assign held     = db;
    assign rise     = db & ~db_q;
    assign conflict = db[1] & db[2];
    assign grant    = pend[0] ? 3'b001 : pend[1] ? 3'b010 : pend[2] ? 3'b100 : 3'b000;
    assign rep_fire[0] = 1'b0;

    // two-flop synchronisers plus a delayed copy of the debounced levels for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= '0;
            s2   <= '0;
            db_q <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_q <= db;
        end
    end

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_deb
            logic [CW-1:0] cnt;
            logic          d;
            assign db[i] = d;
            // level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt <= '0;
                    d   <= 1'b0;
                end else if (s2[i] == d) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt <= '0;
                    d   <= ~d;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
        for (i = 1; i < 3; i++) begin : g_rep
            rep_t          state, state_n;
            logic [CW-1:0] rcnt, rcnt_n;
            logic          fire;
            assign rep_fire[i] = fire;
            // repeat state and countdown registers
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state <= IDLE;
                    rcnt  <= '0;
                end else begin
                    state <= state_n;
                    rcnt  <= rcnt_n;
                end
            end
            // countdown frozen while both speed buttons are held; expiry fires and reloads the period
            always_comb begin
                state_n = state;
                rcnt_n  = rcnt;
                fire    = 1'b0;
                if (!db[i]) begin
                    state_n = IDLE;
                    rcnt_n  = '0;
                end else if (state == IDLE) begin
                    if (rise[i]) begin
                        state_n = WAIT;
                        rcnt_n  = CW'(REPEAT_DELAY);
                    end
                end else if (!conflict) begin
                    if (rcnt == CW'(1)) begin
                        fire    = 1'b1;
                        state_n = REPEAT;
                        rcnt_n  = CW'(REPEAT_PERIOD);
                    end else begin
                        rcnt_n = rcnt - CW'(1);
                    end
                end
            end
        end
    endgenerate

    // pending flags collect events; the highest-priority one is issued as a registered pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend                   <= '0;
            {slower, faster, next} <= '0;
        end else begin
            pend                   <= (pend & ~grant) | rise | rep_fire;
            {slower, faster, next} <= grant;
        end
    end
endmodule

// File: tb/tb_button_pulser.sv
// tb_button_pulser: directed vector and sequence checks for button_pulser
module tb_button_pulser;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_next_raw = 1'b0, btn_faster_raw = 1'b0, btn_slower_raw = 1'b0;
    logic       next, faster, slower;
    logic [2:0] held;

    int checks = 0, errors = 0, cyc = 0;
    int qn[$], qf[$], qs[$];

    typedef struct {
        int         at;
        logic [2:0] raw;
        logic [2:0] pulse;
        logic [2:0] hld;
    } vec_t;
    vec_t tbl[15];

    button_pulser #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .CW(16)) dut (
        .clk(clk), .reset(reset),
        .btn_next_raw(btn_next_raw), .btn_faster_raw(btn_faster_raw), .btn_slower_raw(btn_slower_raw),
        .next(next), .faster(faster), .slower(slower), .held(held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    task automatic chk_q(input string nm, input int got[$], input int exp[$]);
        string sg = "", se = "";
        bit ok;
        ok = got.size() == exp.size();
        for (int j = 0; j < got.size(); j++) begin
            sg = {sg, $sformatf(" %0d", got[j])};
            if (ok && got[j] != exp[j]) ok = 0;
        end
        for (int j = 0; j < exp.size(); j++) se = {se, $sformatf(" %0d", exp[j])};
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got pulses at [%s ] exp [%s ]", nm, sg, se);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (next) qn.push_back(cyc);
        if (faster) qf.push_back(cyc);
        if (slower) qs.push_back(cyc);
        chk($sformatf("excl@%0d", cyc), 32'($countones({slower, faster, next}) > 1), 32'd0);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        {btn_slower_raw, btn_faster_raw, btn_next_raw} = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {26'd0, next, faster, slower, held}, 32'd0);
        reset = 1'b1;
        cyc = 0;
        qn.delete(); qf.delete(); qs.delete();
    endtask

    initial begin
        tbl = '{
            '{9,   3'b001, 3'b000, 3'b000},
            '{14,  3'b001, 3'b000, 3'b000},
            '{16,  3'b001, 3'b000, 3'b001},
            '{17,  3'b001, 3'b001, 3'b001},
            '{18,  3'b001, 3'b000, 3'b001},
            '{109, 3'b000, 3'b000, 3'b001},
            '{114, 3'b000, 3'b000, 3'b001},
            '{116, 3'b000, 3'b000, 3'b000},
            '{130, 3'b111, 3'b000, 3'b000},
            '{137, 3'b111, 3'b000, 3'b111},
            '{138, 3'b111, 3'b001, 3'b111},
            '{139, 3'b111, 3'b010, 3'b111},
            '{140, 3'b111, 3'b100, 3'b111},
            '{141, 3'b000, 3'b000, 3'b111},
            '{150, 3'b000, 3'b000, 3'b000}
        };

        // clean press, release, then simultaneous press
        reset_dut();
        for (int i = 0; i < 15; i++) begin
            run_to(tbl[i].at);
            chk($sformatf("tbl%0d_pulse", i), {29'd0, slower, faster, next}, {29'd0, tbl[i].pulse});
            chk($sformatf("tbl%0d_held", i), {29'd0, held}, {29'd0, tbl[i].hld});
            {btn_slower_raw, btn_faster_raw, btn_next_raw} = tbl[i].raw;
        end
        run_to(170);
        chk_q("press_next", qn, '{17, 138});
        chk_q("press_faster", qf, '{139});
        chk_q("press_slower", qs, '{140});

        // bounce on faster then settle
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            btn_faster_raw = (i % 4) < 2;
            step();
        end
        btn_faster_raw = 1'b1;
        run_to(25);
        btn_faster_raw = 1'b0;
        run_to(50);
        chk_q("bounce_faster", qf, '{20});
        chk_q("bounce_other", {qn, qs}, '{});

        // auto-repeat on slower
        reset_dut();
        btn_slower_raw = 1'b1;
        run_to(60);
        btn_slower_raw = 1'b0;
        run_to(100);
        chk_q("repeat_slower", qs, '{8, 28, 36, 44, 52, 60});
        chk("repeat_held_off", {29'd0, held}, 32'd0);

        // conflict: both speed buttons held, then slower released
        reset_dut();
        {btn_slower_raw, btn_faster_raw} = 2'b11;
        run_to(80);
        btn_slower_raw = 1'b0;
        run_to(112);
        btn_faster_raw = 1'b0;
        run_to(140);
        chk_q("conflict_faster", qf, '{8, 107, 115});
        chk_q("conflict_slower", qs, '{9});

        // asynchronous reset during repeat, then recovery with button still held
        reset_dut();
        btn_slower_raw = 1'b1;
        run_to(28);
        chk("pre_rst_slower", {31'd0, slower}, 32'd1);
        chk("pre_rst_held", {29'd0, held}, 32'd4);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out", {26'd0, next, faster, slower, held}, 32'd0);
        qn.delete(); qf.delete(); qs.delete();
        run_to(33);
        chk("in_rst_out", {26'd0, next, faster, slower, held}, 32'd0);
        reset = 1'b1;
        run_to(45);
        chk_q("post_rst_slower", qs, '{41});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
